// File: rtl/cs_resolve_if.sv
// ============================================================================
// Module : cs_resolve_if
// Brief  : Column-in / digit-out handshake bundle for the carry-save resolver.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface cs_resolve_if #(
    parameter int COL_W   = 20,
    parameter int DIGIT_W = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [COL_W-1:0]   in_c;
    logic [COL_W-1:0]   in_s;
    logic               out_valid;
    logic               out_ready;
    logic [DIGIT_W-1:0] out_digit;
    logic               out_last;

    modport master (
        output in_valid, in_c, in_s, out_ready,
        input  in_ready, out_valid, out_digit, out_last
    );

    modport slave (
        input  in_valid, in_c, in_s, out_ready,
        output in_ready, out_valid, out_digit, out_last
    );
endinterface

`default_nettype wire

// File: rtl/cs_resolve.sv
// ============================================================================
// Module : cs_resolve
// Brief  : Sequential carry-propagate resolver; turns carry-save column pairs
//          into NUM_COLS binary digits plus one final carry digit per frame.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cs_resolve #(
    parameter int DIGIT_W  = 16,
    parameter int COL_W    = 20,
    parameter int NUM_COLS = 8
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    cs_resolve_if.slave   bus,
    output logic          busy
);
    localparam int SUM_W = COL_W + 2;
    localparam int CW    = SUM_W - DIGIT_W;
    localparam int CNT_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

    localparam logic [0:0] S_ACCUM = 1'b0;
    localparam logic [0:0] S_FLUSH = 1'b1;

    logic [0:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CW-1:0]      r_carry;
    logic               r_out_valid;
    logic [DIGIT_W-1:0] r_out_digit;
    logic               r_out_last;
    logic               r_busy;

    logic               w_out_free;
    logic               w_accept;
    logic               w_flush_load;
    logic               w_handoff;
    logic [SUM_W-1:0]   w_sum;

    assign w_out_free   = !r_out_valid || bus.out_ready;
    assign bus.in_ready = (r_state == S_ACCUM) && w_out_free;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_flush_load = (r_state == S_FLUSH) && w_out_free;
    assign w_handoff    = r_out_valid && bus.out_ready;
    // Cannot overflow: 2*(2^COL_W-1) + (2^CW-1) < 2^SUM_W.
    assign w_sum        = SUM_W'(bus.in_c) + SUM_W'(bus.in_s) + SUM_W'(r_carry);

    assign bus.out_valid = r_out_valid;
    assign bus.out_digit = r_out_digit;
    assign bus.out_last  = r_out_last;
    assign busy          = r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_ACCUM;
            r_cnt       <= '0;
            r_carry     <= '0;
            r_out_valid <= 1'b0;
            r_out_digit <= '0;
            r_out_last  <= 1'b0;
        end else if (w_accept) begin
            r_out_digit <= w_sum[DIGIT_W-1:0];
            r_carry     <= w_sum[SUM_W-1:DIGIT_W];
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b1;
            if (r_cnt == CNT_W'(NUM_COLS - 1)) begin
                r_cnt   <= '0;
                r_state <= S_FLUSH;
            end else begin
                r_cnt   <= r_cnt + CNT_W'(1);
            end
        end else if (w_flush_load) begin
            r_out_digit <= {{(DIGIT_W - CW){1'b0}}, r_carry};
            r_out_last  <= 1'b1;
            r_out_valid <= 1'b1;
            r_carry     <= '0;
            r_state     <= S_ACCUM;
        end else if (w_handoff) begin
            r_out_valid <= 1'b0;
        end
    end

    // A new frame's first accept may coincide with the previous flush handoff; set wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
        end else if (w_accept) begin
            r_busy <= 1'b1;
        end else if (w_handoff && r_out_last) begin
            r_busy <= 1'b0;
        end
    end
endmodule

`default_nettype wire
